// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder with modifier tracking and an event FIFO.
// Turns the receiver's byte strobes into {ext, release, code} key events,
// strips the E0/F0/E1 prefixes, tracks Shift/Ctrl/Alt and buffers events
// in a first-word-fall-through FIFO with a valid/ack handshake.
// Optional build macro KBD_REPEAT_FILTER_EN suppresses typematic repeats.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               clock_25,
  input  logic               reset_n,
  input  logic               keyb_ready,
  input  logic [7:0]         keyb_data,
  output logic               ev_valid,
  input  logic               ev_ack,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_release,
  output logic [2:0]         mods,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ovf,
  output logic               kbd_err,
  input  logic               err_clr
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LevelFull = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {StIdle, StE0, StF0, StE0F0, StPause} state_e;

  state_e     state;
  logic [2:0] skip_cnt;

  // Byte classification
  logic is_e0, is_f0, is_e1, is_ctl, is_bad;
  assign is_e0  = (keyb_data == 8'hE0);
  assign is_f0  = (keyb_data == 8'hF0);
  assign is_e1  = (keyb_data == 8'hE1);
  // Self-test pass, ack, echo and resend replies carry no key information
  assign is_ctl = (keyb_data == 8'hAA) || (keyb_data == 8'hFA) ||
                  (keyb_data == 8'hEE) || (keyb_data == 8'hFE);
  assign is_bad = (keyb_data == 8'h00) || (keyb_data == 8'hFF);

  logic       emit, emit_ext, emit_rel, dec_err, is_pause;
  logic [7:0] emit_code;

  assign is_pause = (state == StPause);

  // Event produced by the byte sampled this cycle
  always_comb begin
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_rel  = 1'b0;
    emit_code = keyb_data;
    dec_err   = 1'b0;
    if (keyb_ready) begin
      case (state)
        StIdle: begin
          if (is_bad) begin
            dec_err = 1'b1;
          end else if (!(is_e0 || is_f0 || is_e1 || is_ctl)) begin
            emit = 1'b1;
          end
        end
        StE0: begin
          if (is_e1) begin
            dec_err = 1'b1;
          end else if (!is_f0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        StF0, StE0F0: begin
          if (is_e0 || is_f0 || is_e1) begin
            dec_err = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_rel = 1'b1;
            emit_ext = (state == StE0F0);
          end
        end
        StPause: begin
          if (skip_cnt == 3'd1) begin
            emit      = 1'b1;
            emit_code = 8'hE1;
          end
        end
        default: ;
      endcase
    end
  end

  // Prefix state machine; only advances on byte strobes
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= StIdle;
      skip_cnt <= 3'd0;
    end else if (keyb_ready) begin
      case (state)
        StIdle: begin
          if (is_e0) state <= StE0;
          else if (is_f0) state <= StF0;
          else if (is_e1) begin
            state    <= StPause;
            skip_cnt <= 3'd7;
          end
        end
        StE0: begin
          if (is_e1) begin
            state    <= StPause;
            skip_cnt <= 3'd7;
          end else if (is_f0) begin
            state <= StE0F0;
          end else begin
            state <= StIdle;
          end
        end
        StF0, StE0F0: begin
          if (is_e0) state <= StE0;
          else if (is_f0) state <= StF0;
          else if (is_e1) begin
            state    <= StPause;
            skip_cnt <= 3'd7;
          end else begin
            state <= StIdle;
          end
        end
        StPause: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // E0 12 / E0 59 are the keyboard's fake shifts around extended keys
  logic fake_shift, repeat_hit, accept;
  assign fake_shift = emit && emit_ext && ((emit_code == 8'h12) || (emit_code == 8'h59));
  assign accept     = emit && !fake_shift && !repeat_hit;

`ifdef KBD_REPEAT_FILTER_EN
  logic [8:0] last_make;
  logic       last_valid;
  logic       last_match;

  assign last_match = last_valid && (last_make == {emit_ext, emit_code});
  assign repeat_hit = emit && !emit_rel && !is_pause && last_match;

  // Remember the most recent make so held-key repeats can be swallowed
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      last_make  <= 9'd0;
      last_valid <= 1'b0;
    end else if (accept && !emit_rel && !is_pause) begin
      last_make  <= {emit_ext, emit_code};
      last_valid <= 1'b1;
    end else if (accept && emit_rel && last_match) begin
      last_valid <= 1'b0;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  // Per-side modifier state: [0] LShift [1] RShift [2] LCtrl [3] RCtrl [4] LAlt [5] RAlt
  logic [5:0] mod_side;

  // Modifiers follow accepted events, even ones the FIFO has to drop
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      mod_side <= 6'd0;
    end else if (accept) begin
      case ({emit_ext, emit_code})
        9'h012:  mod_side[0] <= !emit_rel;
        9'h059:  mod_side[1] <= !emit_rel;
        9'h014:  mod_side[2] <= !emit_rel;
        9'h114:  mod_side[3] <= !emit_rel;
        9'h011:  mod_side[4] <= !emit_rel;
        9'h111:  mod_side[5] <= !emit_rel;
        default: ;
      endcase
    end
  end

  assign mods = {mod_side[5] | mod_side[4], mod_side[3] | mod_side[2], mod_side[1] | mod_side[0]};

  // Event FIFO
  logic [9:0]         mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               pop, full, write;

  assign pop   = ev_valid && ev_ack;
  assign full  = (fifo_level == LevelFull);
  // When full, a same-cycle pop frees the slot being written
  assign write = accept && (!full || pop);

  // Storage, pointers and level
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) mem[i] <= 10'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (write) begin
        mem[wr_ptr] <= {emit_ext, emit_rel, emit_code};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({write, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky error flags; a new set beats a simultaneous clear
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      ovf     <= 1'b0;
      kbd_err <= 1'b0;
    end else begin
      if (accept && full && !pop) ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (dec_err) kbd_err <= 1'b1;
      else if (err_clr) kbd_err <= 1'b0;
    end
  end

  assign ev_valid = (fifo_level != '0);
  assign {ev_ext, ev_release, ev_code} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scan-code sequences followed by
// random byte streams, all checked against an event-level reference model.
// Honours KBD_REPEAT_FILTER_EN the same way the design does.
module tb_ps2_scancode_decoder;

  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned DEPTH   = 1 << FIFO_AW;

  logic             clock_25 = 1'b0;
  logic             reset_n  = 1'b0;
  logic             keyb_ready = 1'b0;
  logic [7:0]       keyb_data  = 8'h00;
  logic             ev_ack  = 1'b0;
  logic             err_clr = 1'b0;
  logic             ev_valid, ev_ext, ev_release, ovf, kbd_err;
  logic [7:0]       ev_code;
  logic [2:0]       mods;
  logic [FIFO_AW:0] fifo_level;

  ps2_scancode_decoder #(.FIFO_AW(FIFO_AW)) dut (
    .clock_25   (clock_25),
    .reset_n    (reset_n),
    .keyb_ready (keyb_ready),
    .keyb_data  (keyb_data),
    .ev_valid   (ev_valid),
    .ev_ack     (ev_ack),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_release (ev_release),
    .mods       (mods),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .kbd_err    (kbd_err),
    .err_clr    (err_clr)
  );

  always #20 clock_25 = ~clock_25;

  int checks = 0;
  int errors = 0;

  // Reference model: pending prefix flags, expected event queue, held keys
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ev_t;

  ev_t        m_q[$];
  logic       m_ext, m_rel;
  int         m_pause;
  logic       m_held [512];
  logic       m_ovf, m_err;
  logic       m_lm_v;
  logic [8:0] m_lm;

  task automatic model_reset();
    m_q.delete();
    m_ext = 1'b0; m_rel = 1'b0; m_pause = 0;
    m_ovf = 1'b0; m_err = 1'b0; m_lm_v = 1'b0; m_lm = 9'd0;
    for (int i = 0; i < 512; i++) m_held[i] = 1'b0;
  endtask

  function automatic logic [2:0] model_mods();
    return {m_held[9'h111] | m_held[9'h011],
            m_held[9'h114] | m_held[9'h014],
            m_held[9'h059] | m_held[9'h012]};
  endfunction

  task automatic model_update(input logic rdy, input logic [7:0] b, input logic ack,
                              input logic clr);
    logic have, ext, rel, pause_ev, set_err, set_ovf, pop, keep;
    logic [7:0] code;
    ev_t e;
    have = 0; ext = 0; rel = 0; pause_ev = 0; set_err = 0; set_ovf = 0; code = b;
    pop = ack && (m_q.size() != 0);
    if (rdy) begin
      if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) begin have = 1; code = 8'hE1; pause_ev = 1; end
      end else if (b == 8'hE1) begin
        if (m_ext || m_rel) set_err = 1;
        m_ext = 0; m_rel = 0; m_pause = 7;
      end else if (b == 8'hE0 && !(m_ext && !m_rel)) begin
        if (m_rel) set_err = 1;
        m_ext = 1; m_rel = 0;
      end else if (b == 8'hF0 && m_rel) begin
        set_err = 1; m_ext = 0; m_rel = 1;
      end else if (b == 8'hF0) begin
        m_rel = 1;
      end else if (!m_ext && !m_rel) begin
        if (b == 8'h00 || b == 8'hFF) set_err = 1;
        else if (!(b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) have = 1;
      end else begin
        have = 1; ext = m_ext; rel = m_rel; m_ext = 0; m_rel = 0;
      end
    end
    keep = have && !(ext && (code == 8'h12 || code == 8'h59));
`ifdef KBD_REPEAT_FILTER_EN
    if (keep && !rel && !pause_ev) begin
      if (m_lm_v && m_lm == {ext, code}) keep = 0;
      else begin m_lm = {ext, code}; m_lm_v = 1; end
    end else if (keep && rel && m_lm_v && m_lm == {ext, code}) begin
      m_lm_v = 0;
    end
`endif
    if (keep && !pause_ev) m_held[{ext, code}] = !rel;
    if (pop) void'(m_q.pop_front());
    if (keep) begin
      if (m_q.size() < DEPTH) begin
        e.ext = ext; e.rel = rel; e.code = code;
        m_q.push_back(e);
      end else begin
        set_ovf = 1;
      end
    end
    m_ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_err = set_err ? 1'b1 : (clr ? 1'b0 : m_err);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(ev_valid), 32'(m_q.size() != 0));
    chk({tag, ".level"}, 32'(fifo_level), 32'(m_q.size()));
    chk({tag, ".mods"}, 32'(mods), 32'(model_mods()));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".kbd_err"}, 32'(kbd_err), 32'(m_err));
    if (m_q.size() != 0) begin
      chk({tag, ".head"}, 32'({ev_ext, ev_release, ev_code}),
          32'({m_q[0].ext, m_q[0].rel, m_q[0].code}));
    end
  endtask

  // One clock: inputs driven at the falling edge, model stepped at the rising edge
  task automatic step(input logic rdy, input logic [7:0] b, input logic ack, input logic clr);
    @(negedge clock_25);
    keyb_ready = rdy; keyb_data = b; ev_ack = ack; err_clr = clr;
    @(posedge clock_25);
    model_update(rdy, b, ack, clr);
    #1;
    keyb_ready = 1'b0; ev_ack = 1'b0; err_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 && m_q.size() != 0; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_all(tag);
    end
  endtask

  task automatic do_reset();
    @(negedge clock_25);
    #5 reset_n = 1'b0;
    model_reset();
    #10;
    @(negedge clock_25);
    reset_n = 1'b1;
  endtask

  logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h14, 8'h11, 8'h1C,
                            8'h75, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hEE, 8'h23, 8'h6B};
  logic [7:0] ovf_codes [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};

  initial begin
    model_reset();
    #50;
    // Reset values
    chk("rst.valid", 32'(ev_valid), 32'd0);
    chk("rst.level", 32'(fifo_level), 32'd0);
    chk("rst.mods", 32'(mods), 32'd0);
    chk("rst.flags", 32'({ovf, kbd_err}), 32'd0);
    chk("rst.head", 32'({ev_ext, ev_release, ev_code}), 32'd0);
    @(negedge clock_25);
    reset_n = 1'b1;

    // Make then break of the same key
    send(8'h1C); send(8'hF0); send(8'h1C);
    check_all("mkbrk");
    chk("mkbrk.level2", 32'(fifo_level), 32'd2);
    chk("mkbrk.head0", 32'({ev_ext, ev_release, ev_code}), 32'h01C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("mkbrk.head1", 32'({ev_ext, ev_release, ev_code}), 32'h11C);
    drain("mkbrk.drain");

    // Extended make/break
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check_all("ext");
    chk("ext.head", 32'({ev_ext, ev_release, ev_code}), 32'h275);
    drain("ext.drain");
    send(8'hE0); send(8'h11);
    chk("ralt.mods", 32'(mods), 32'h4);
    send(8'hE0); send(8'hF0); send(8'h11);
    chk("ralt.rel", 32'(mods), 32'h0);
    check_all("ralt");
    drain("ralt.drain");

    // Both shifts, then a fake shift
    send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
    chk("shift.rheld", 32'(mods[0]), 32'd1);
    send(8'hF0); send(8'h59);
    chk("shift.none", 32'(mods[0]), 32'd0);
    check_all("shift");
    drain("shift.drain");
    send(8'hE0); send(8'h12);
    chk("fake.level", 32'(fifo_level), 32'd0);
    check_all("fake");

    // Pause sequence yields a single make
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause.level", 32'(fifo_level), 32'd1);
    chk("pause.head", 32'({ev_ext, ev_release, ev_code}), 32'h0E1);
    chk("pause.err", 32'(kbd_err), 32'd0);
    send(8'h1C);
    check_all("pause");
    drain("pause.drain");

    // Overflow, then push with pop while full
    for (int i = 0; i < 5; i++) send(ovf_codes[i]);
    chk("ovf.level", 32'(fifo_level), 32'd4);
    chk("ovf.flag", 32'(ovf), 32'd1);
    chk("ovf.head", 32'({ev_ext, ev_release, ev_code}), 32'h01C);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf.clr", 32'(ovf), 32'd0);
    step(1'b1, 8'h2B, 1'b1, 1'b0);
    chk("ovf.pushpop.level", 32'(fifo_level), 32'd4);
    chk("ovf.pushpop.flag", 32'(ovf), 32'd0);
    check_all("ovf");
    drain("ovf.drain");

    // Typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef KBD_REPEAT_FILTER_EN
    chk("repeat.level", 32'(fifo_level), 32'd3);
`else
    chk("repeat.level", 32'(fifo_level), 32'd4);
    chk("repeat.ovf", 32'(ovf), 32'd1);
`endif
    check_all("repeat");
    drain("repeat.drain");
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Overrun byte and error clear
    send(8'hFF);
    chk("ff.err", 32'(kbd_err), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ff.clr", 32'(kbd_err), 32'd0);

    // Reset in the middle of an E0 prefix
    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk("midrst.head", 32'({ev_ext, ev_release, ev_code}), 32'h01C);
    check_all("midrst");
    drain("midrst.drain");

    // Random byte streams
    for (int n = 0; n < 1500; n++) begin
      logic       rdy, ack, clr;
      logic [7:0] b;
      rdy = ($urandom_range(3) != 0);
      b   = ($urandom_range(7) == 0) ? 8'($urandom) : pool[$urandom_range(15)];
      ack = ($urandom_range(2) == 0);
      clr = ($urandom_range(19) == 0);
      if ($urandom_range(499) == 0) do_reset();
      step(rdy, b, ack, clr);
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
